// File: rtl/spi_pkg.sv
// Shared SPI constants: default frame width, bit-counter sizing and chip-select polarity.
package spi_pkg;

  localparam int unsigned defaultWidth = 8;

  // Always at least one counter bit, even for degenerate widths.
  function automatic int unsigned cntWidth(input int unsigned width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

  localparam int unsigned defaultCntWidth = cntWidth(defaultWidth);

  localparam logic csActive = 1'b0;

endpackage

// File: rtl/slave.sv
// SPI mode-0 slave: MOSI sampled on rising sclk, MISO shifted on falling sclk, MSB first.
// Frames repeat back-to-back while cs stays active; an inactive cs discards any partial frame.
module slave
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH = defaultWidth
) (
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             sclk,
  input  logic             cs,
  input  logic             MOSI,
  output logic             MISO
);

  localparam int unsigned CntW = cntWidth(WIDTH);
  localparam logic [CntW-1:0] lastBit = CntW'(WIDTH - 1);

  logic [WIDTH-1:0] rxShift;
  logic [CntW-1:0]  bitCnt;
  logic [WIDTH-1:0] txShiftQ;
  logic             txValidQ;
  logic [WIDTH-1:0] txWord;
  logic             csIdle;

  assign csIdle = (cs != csActive);

  // Receive shifter and bit counter are held clear for as long as cs is inactive.
  always_ff @(posedge sclk or posedge reset or posedge cs) begin
    if (reset) begin
      rxShift <= '0;
      bitCnt  <= '0;
    end else if (csIdle) begin
      rxShift <= '0;
      bitCnt  <= '0;
    end else begin
      rxShift <= {rxShift[WIDTH-2:0], MOSI};
      bitCnt  <= (bitCnt == lastBit) ? '0 : bitCnt + 1'b1;
    end
  end

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      dout <= '0;
    end else if (!csIdle && (bitCnt == lastBit)) begin
      dout <= {rxShift[WIDTH-2:0], MOSI};
    end
  end

  // Until the first falling edge of a frame the transmit word is din itself, so the
  // shifter tracks din through reset and idle without an asynchronous data load.
  always_ff @(negedge sclk or posedge reset or posedge cs) begin
    if (reset) begin
      txValidQ <= 1'b0;
      txShiftQ <= '0;
    end else if (csIdle) begin
      txValidQ <= 1'b0;
      txShiftQ <= '0;
    end else begin
      txValidQ <= 1'b1;
      if (bitCnt == '0) begin
        txShiftQ <= din;
      end else begin
        txShiftQ <= {txWord[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign txWord = txValidQ ? txShiftQ : din;
  assign MISO   = csIdle ? 1'bz : txWord[WIDTH-1];

endmodule

// File: tb/tb_slave.sv
// Directed bench for the SPI slave: reset, single and back-to-back frames, cs abort, reset abort.
module tb_slave;

  logic       reset;
  logic [7:0] din;
  logic [7:0] dout;
  logic       sclk;
  logic       cs;
  logic       mosi;
  tri1        miso;  // pulled high so a released MISO reads as 1

  int nAsserts = 0;
  int nFails   = 0;

  slave #(.WIDTH(8)) dut (
    .reset(reset),
    .din  (din),
    .dout (dout),
    .sclk (sclk),
    .cs   (cs),
    .MOSI (mosi),
    .MISO (miso)
  );

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One mode-0 bit: drive MOSI, sample MISO while sclk is low, then pulse sclk.
  task automatic spiBit(input logic b, output logic r);
    mosi = b;
    #5;
    r = miso;
    sclk = 1'b1;
    #5;
    sclk = 1'b0;
    #5;
  endtask

  task automatic spiFrame(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spiBit(tx[i], r);
      rx[i] = r;
    end
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] txb;
    logic       r;

    sclk  = 1'b0;
    mosi  = 1'b0;
    din   = 8'h33;
    cs    = 1'b1;
    reset = 1'b1;
    #10;
    chk8("reset_dout", dout, 8'h00);
    chk1("reset_miso_released", miso, 1'b1);

    reset = 1'b0;
    #5;
    cs = 1'b0;
    #5;
    chk1("post_reset_miso_msb", miso, 1'b0);
    chk8("post_reset_dout", dout, 8'h00);

    // Single frame
    spiFrame(8'hCC, rx);
    chk8("single_dout", dout, 8'hCC);
    chk8("single_miso", rx, 8'h33);
    cs = 1'b1;
    #10;
    chk8("idle_dout_held", dout, 8'hCC);

    // Back-to-back frames; din changes mid-frame 1 and must not disturb it
    din = 8'hAA;
    cs  = 1'b0;
    #5;
    txb = 8'hC3;
    for (int i = 7; i >= 0; i--) begin
      if (i == 3) din = 8'h71;
      spiBit(txb[i], r);
      rx[i] = r;
      if (i == 4) chk8("b2b_mid_dout_held", dout, 8'hCC);
    end
    chk8("b2b1_dout", dout, 8'hC3);
    chk8("b2b1_miso", rx, 8'hAA);
    spiFrame(8'hF0, rx);
    chk8("b2b2_dout", dout, 8'hF0);
    chk8("b2b2_miso", rx, 8'h71);
    cs = 1'b1;
    #10;

    // cs abort after 4 bits of 0x93
    din = 8'hA5;
    cs  = 1'b0;
    #5;
    txb = 8'h93;
    for (int i = 7; i >= 4; i--) spiBit(txb[i], r);
    cs = 1'b1;
    #5;
    chk8("abort_dout_kept", dout, 8'hF0);
    chk1("abort_miso_released", miso, 1'b1);
    #5;
    cs = 1'b0;
    #5;
    spiFrame(8'hB2, rx);
    chk8("after_abort_dout", dout, 8'hB2);
    chk8("after_abort_miso", rx, 8'hA5);
    cs = 1'b1;
    #10;

    // Reset mid-frame after 5 bits
    din = 8'h3C;
    cs  = 1'b0;
    #5;
    txb = 8'h5A;
    for (int i = 7; i >= 3; i--) spiBit(txb[i], r);
    reset = 1'b1;
    #1;
    chk8("midreset_dout_async", dout, 8'h00);
    chk1("midreset_miso_tracks_din", miso, 1'b0);
    din = 8'hBC;
    #1;
    chk1("midreset_miso_tracks_new_din", miso, 1'b1);
    din = 8'h3C;
    #3;
    reset = 1'b0;
    #5;
    spiFrame(8'h90, rx);
    chk8("after_reset_dout", dout, 8'h90);
    chk8("after_reset_miso", rx, 8'h3C);
    cs = 1'b1;
    #10;

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
